// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: default widths and the skid-stage state encoding.
// Imported by every pipeline stage that carries a payload through a skid buffer.
package pipe_stage_skid_pkg;

   localparam int unsigned PIPE_DATA_W  = 32;
   localparam int unsigned PIPE_N_STALL = 2;
   localparam int unsigned PIPE_CNT_W   = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with stall, flush (irq/clr) and stall counter.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; stall[N_STALL], irq, clr control;
// stall_cnt saturating count of cycles stalled while holding data.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned DATA_W  = PIPE_DATA_W,
   parameter int unsigned N_STALL = PIPE_N_STALL,
   parameter int unsigned CNT_W   = PIPE_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [N_STALL-1:0] stall,
   input  logic               irq,
   input  logic               clr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [CNT_W-1:0]   stall_cnt
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic stall_eff;
   logic flush;
   logic push;
   logic pop;

   // irq overrides any stall source; it flushes instead.
   assign stall_eff = (|stall) && !irq;
   assign flush     = irq || clr;

   assign in_ready  = (state_q != ST_FULL) && !stall_eff;
   assign out_valid = (state_q != ST_EMPTY) && !stall_eff;
   assign out_data  = main_q;
   assign stall_cnt = cnt_q;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (push) begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  main_d  = skid_q;
                  skid_d  = '0;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   // Counts stalled-while-occupied cycles; flush does not clear it.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_eff && (state_q != ST_EMPTY) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_skid;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic [1:0]  stall;
   logic        irq;
   logic        clr;
   logic        out_ready;

   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [15:0] stall_cnt;

   logic        in_ready4, out_valid4;
   logic [31:0] out_data4;
   logic [3:0]  stall_cnt4;

   pipe_stage_skid u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .stall(stall), .irq(irq), .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
      .stall(stall), .irq(irq), .clr(clr),
      .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
      .stall_cnt(stall_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   logic [31:0] m_q[$];
   logic [31:0] m_main;
   int          m_c16;
   int          m_c4;
   bit          m_ok = 0;

   // DUT values sampled before the edge of the last cycle
   logic        s_ir, s_ov;
   logic [31:0] s_od;
   logic [15:0] s_c16;
   logic [3:0]  s_c4;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic iv,
                        input logic [31:0] d, input logic [1:0] st,
                        input logic iq, input logic cl,
                        input logic ordy);
      logic se, eir, eov, fl, pu, po;
      @(negedge clk);
      rst = r; in_valid = iv; in_data = d; stall = st;
      irq = iq; clr = cl; out_ready = ordy;
      #1;
      se  = (|st) && !iq;
      fl  = iq || cl;
      eir = (m_q.size() != 2) && !se;
      eov = (m_q.size() != 0) && !se;
      s_ir = in_ready; s_ov = out_valid; s_od = out_data;
      s_c16 = stall_cnt; s_c4 = stall_cnt4;
      if (m_ok) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, eir});
         chk("out_valid", {31'd0, out_valid}, {31'd0, eov});
         chk("out_data", out_data, m_main);
         chk("stall_cnt", {16'd0, stall_cnt}, m_c16);
         chk("stall_cnt_w4", {28'd0, stall_cnt4}, m_c4);
         chk("out_valid_w4", {31'd0, out_valid4}, {31'd0, eov});
      end
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_main = '0;
         m_c16 = 0;
         m_c4 = 0;
         m_ok = 1;
      end else begin
         if (se && m_q.size() != 0) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
         end
         if (fl) begin
            m_q.delete();
            m_main = '0;
         end else begin
            pu = iv && eir;
            po = eov && ordy;
            if (po) void'(m_q.pop_front());
            if (pu) m_q.push_back(d);
            if (m_q.size() != 0) m_main = m_q[0];
         end
      end
   endtask

   typedef struct {
      logic        r, iv;
      logic [31:0] d;
      logic [1:0]  st;
      logic        iq, cl, ordy;
      logic        chk;
      logic        eir, eov;
      logic [31:0] eod;
   } vec_t;

   function automatic vec_t mk(logic r, logic iv, logic [31:0] d,
                               logic [1:0] st, logic iq, logic cl,
                               logic ordy, logic c, logic eir,
                               logic eov, logic [31:0] eod);
      vec_t v;
      v.r = r; v.iv = iv; v.d = d; v.st = st; v.iq = iq; v.cl = cl;
      v.ordy = ordy; v.chk = c; v.eir = eir; v.eov = eov; v.eod = eod;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      rst = 1'b1; in_valid = 0; in_data = '0; stall = '0;
      irq = 0; clr = 0; out_ready = 0;

      tbl[0]  = mk(1,0,32'h0,2'b00,0,0,0, 0,1,0,32'h0);
      tbl[1]  = mk(0,0,32'h0,2'b00,0,0,0, 1,1,0,32'h0);
      tbl[2]  = mk(0,1,32'hA5A5A5A5,2'b00,0,0,1, 1,1,0,32'h0);
      tbl[3]  = mk(0,0,32'h0,2'b00,0,0,1, 1,1,1,32'hA5A5A5A5);
      tbl[4]  = mk(0,0,32'h0,2'b00,0,0,0, 1,1,0,32'hA5A5A5A5);
      tbl[5]  = mk(0,1,32'h1,2'b00,0,0,0, 1,1,0,32'hA5A5A5A5);
      tbl[6]  = mk(0,1,32'h2,2'b00,0,0,0, 1,1,1,32'h1);
      tbl[7]  = mk(0,1,32'h3,2'b00,0,0,0, 1,0,1,32'h1);
      tbl[8]  = mk(0,1,32'h3,2'b00,0,0,1, 1,0,1,32'h1);
      tbl[9]  = mk(0,1,32'h3,2'b00,0,0,1, 1,1,1,32'h2);
      tbl[10] = mk(0,0,32'h0,2'b00,0,0,1, 1,1,1,32'h3);
      tbl[11] = mk(0,0,32'h0,2'b00,0,0,0, 1,1,0,32'h3);
      tbl[12] = mk(0,1,32'h10,2'b00,0,0,0, 1,1,0,32'h3);
      tbl[13] = mk(0,1,32'h20,2'b00,0,1,1, 1,1,1,32'h10);
      tbl[14] = mk(0,0,32'h0,2'b00,0,0,1, 1,1,0,32'h0);
      tbl[15] = mk(0,0,32'h0,2'b00,0,0,0, 1,1,0,32'h0);

      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].st,
               tbl[i].iq, tbl[i].cl, tbl[i].ordy);
         if (tbl[i].chk) begin
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, s_ir}, {31'd0, tbl[i].eir});
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, s_ov}, {31'd0, tbl[i].eov});
            chk($sformatf("tbl%0d_out_data", i), s_od, tbl[i].eod);
            chk($sformatf("tbl%0d_stall_cnt", i), {16'd0, s_c16}, 32'd0);
         end
      end

      // stall while FULL for 5 cycles
      cycle(1,0,32'h0,2'b00,0,0,0);
      cycle(0,1,32'h11,2'b00,0,0,0);
      cycle(0,1,32'h22,2'b00,0,0,0);
      for (int i = 0; i < 5; i++) begin
         cycle(0,1,32'h33,2'b10,0,0,1);
         chk("stallfull_out_valid", {31'd0, s_ov}, 32'd0);
         chk("stallfull_in_ready", {31'd0, s_ir}, 32'd0);
         chk("stallfull_out_data", s_od, 32'h11);
      end
      cycle(0,0,32'h0,2'b00,0,0,0);
      chk("stall5_cnt", {16'd0, s_c16}, 32'd5);

      // irq with stall while FULL
      cycle(0,0,32'h0,2'b10,1,0,0);
      cycle(0,0,32'h0,2'b00,0,0,0);
      chk("irq_out_valid", {31'd0, s_ov}, 32'd0);
      chk("irq_out_data", s_od, 32'h0);
      chk("irq_cnt_held", {16'd0, s_c16}, 32'd5);

      // saturation with CNT_W=4, then reset
      cycle(1,0,32'h0,2'b00,0,0,0);
      cycle(0,1,32'h7,2'b00,0,0,0);
      for (int i = 0; i < 20; i++) cycle(0,0,32'h0,2'b01,0,0,0);
      cycle(0,0,32'h0,2'b00,0,0,0);
      chk("sat_cnt_w4", {28'd0, s_c4}, 32'd15);
      chk("sat_cnt_w16", {16'd0, s_c16}, 32'd20);
      cycle(1,1,32'h9,2'b00,0,0,1);
      cycle(0,0,32'h0,2'b00,0,0,0);
      chk("rst_cnt_w4", {28'd0, s_c4}, 32'd0);
      chk("rst_out_valid", {31'd0, s_ov}, 32'd0);
      chk("rst_in_ready", {31'd0, s_ir}, 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0] st;
         st = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cycle($urandom_range(0, 99) == 0,
               1'($urandom_range(0, 1)),
               $urandom,
               st,
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 29) == 0,
               1'($urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload carried through the stage.
REQ-002 Parameter N_STALL, default 2: number of independent stall request inputs.
REQ-003 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream offers a payload.
REQ-008 in_ready  output  1  stage accepts a payload this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 stall  input  N_STALL  per-source stall requests.
REQ-011 irq  input  1  interrupt request; flushes the stage and overrides stall.
REQ-012 clr  input  1  pipeline clear; flushes the stage.
REQ-013 out_valid  output  1  stage presents a payload.
REQ-014 out_ready  input  1  downstream consumes out_data this cycle.
REQ-015 out_data  output  DATA_W  presented payload.
REQ-016 stall_cnt  output  CNT_W  saturating count of stalled-while-occupied cycles.

Function
REQ-017 stall_eff SHALL be (|stall) && !irq; flush SHALL be irq || clr. Both are combinational.
REQ-018 Storage SHALL be two entries: main (presented) and skid. The states SHALL be EMPTY, ONE (main valid) and FULL (main and skid valid).
REQ-019 in_ready SHALL be (state != FULL) && !stall_eff.
REQ-020 out_valid SHALL be (state != EMPTY) && !stall_eff.
REQ-021 out_data SHALL be the main entry in every state, including during a stall.
REQ-022 A push SHALL be in_valid && in_ready && !flush. A pop SHALL be out_valid && out_ready && !flush.
REQ-023 EMPTY: a push SHALL load main and go to ONE.
REQ-024 ONE: push with pop SHALL load main from in_data and stay in ONE; push without pop SHALL load skid and go to FULL; pop without push SHALL go to EMPTY.
REQ-025 FULL: a pop SHALL move skid into main, clear skid and go to ONE. No push is possible in FULL.
REQ-026 With no push and no pop, state and data SHALL hold.
REQ-027 Flush SHALL take priority over push, pop and stall. The next state SHALL be EMPTY and main and skid data SHALL be zero.
REQ-028 An irq concurrent with a stall SHALL flush; the stall SHALL be ignored.
REQ-029 Latency: a payload pushed into EMPTY SHALL be presented on out_data and out_valid in the next cycle (1 cycle).
REQ-030 Order SHALL be strictly FIFO. There SHALL be no loss or duplication absent a flush.
REQ-031 stall_cnt SHALL increment by 1 each cycle stall_eff && state != EMPTY, and SHALL saturate at 2^CNT_W-1.
REQ-032 stall_cnt SHALL be unaffected by flush and cleared only by rst.

Reset
REQ-033 On rst, state SHALL be EMPTY, main and skid data 0 and stall_cnt 0.
REQ-034 On rst, out_valid SHALL be 0, out_data 0, and in_ready 1 when stall_eff is 0.
REQ-035 A reset mid-operation SHALL discard both entries with no output handshake.
REQ-036 rst SHALL dominate flush, push and pop.

Structure
REQ-037 The state encoding (EMPTY=0, ONE=1, FULL=2) and the default DATA_W/CNT_W constants SHALL live in the shared pipeline package.
REQ-038 The block SHALL be a single module with no sub-module. The EXE/MEM and other stage wrappers SHALL instantiate it with DATA_W equal to their packed field width.

Verification
REQ-039 Push 0xA5A5A5A5 into EMPTY with out_ready=1 -> the next cycle out_valid=1 and out_data=0xA5A5A5A5; the following cycle state is EMPTY.
REQ-040 Push 3 words (1,2,3) back-to-back with out_ready=0 -> in_ready drops after the 2nd push, the 3rd is held upstream; releasing out_ready outputs 1,2,3 in order.
REQ-041 Hold FULL, assert stall[1]=1 for 5 cycles -> out_valid=0, in_ready=0, data unchanged, stall_cnt=5.
REQ-042 Stall asserted with irq=1 in FULL -> the next cycle is EMPTY, out_data=0 and stall_cnt unchanged.
REQ-043 clr in the same cycle as a push and pop in ONE -> the next state is EMPTY and the pushed word is never output.
REQ-044 With CNT_W=4, stall while occupied for 20 cycles -> stall_cnt=15 (saturated); then rst -> stall_cnt=0, out_valid=0, in_ready=1.
